cle_seq_gen: RTL and testbench

CLE_SEQ_GEN -- requirements
Module: cle_seq_gen

---
 rtl/cle_seq_gen.sv | 113 +++++++++++
 tb/tb_cle_seq_gen.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/cle_seq_gen.sv
`default_nettype none
// ============================================================================
// Module  : cle_seq_gen
// Brief   : Qualified bus-cycle sequencer; counts to a captured target, then
//           pulses strobe and holds done until qualification drops.
// Revision: 1.0
// ============================================================================
module cle_seq_gen #(
    parameter int         STATE_W = 6,
    parameter int         ADDR_W  = 4,
    parameter logic [1:0] BASE    = 2'b01,
    parameter bit         GRAY    = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sser_n,
    input  logic [1:0]         ba_hi,
    input  logic [ADDR_W-1:0]  ba_field,
    input  logic               br_w,
    input  logic               oe,
    output logic [STATE_W-1:0] state_q,
    output logic               state_en,
    output logic               sdrd,
    output logic               sdrd_en,
    output logic               strobe,
    output logic               done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_RUN   = 3'd2,
        S_MATCH = 3'd3,
        S_DONE  = 3'd4
    } fsm_t;

    fsm_t               fsm_q, fsm_d;
    logic [STATE_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0]  tgt_q, tgt_d;
    logic [STATE_W-1:0] tgt_ext;
    logic               qual;

    assign qual = ~sser_n & (ba_hi == BASE) & br_w;

    always_comb begin
        tgt_ext               = '0;
        tgt_ext[ADDR_W-1:0]   = tgt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q <= S_IDLE;
            cnt_q <= '0;
            tgt_q <= '0;
        end else begin
            fsm_q <= fsm_d;
            cnt_q <= cnt_d;
            tgt_q <= tgt_d;
        end
    end

    // Loss of qualification overrides every other transition.
    always_comb begin
        fsm_d = fsm_q;
        cnt_d = cnt_q;
        tgt_d = tgt_q;
        if (!qual) begin
            fsm_d = S_IDLE;
            cnt_d = '0;
        end else begin
            case (fsm_q)
                S_IDLE: begin
                    fsm_d = S_ARM;
                    tgt_d = ba_field;
                    cnt_d = '0;
                end
                S_ARM: begin
                    fsm_d = S_RUN;
                    cnt_d = '0;
                end
                S_RUN: begin
                    if (cnt_q == tgt_ext) begin
                        fsm_d = S_MATCH;
                    end else begin
                        cnt_d = cnt_q + STATE_W'(1);
                    end
                end
                S_MATCH: fsm_d = S_DONE;
                S_DONE:  fsm_d = S_DONE;
                default: begin
                    fsm_d = S_IDLE;
                    cnt_d = '0;
                end
            endcase
        end
    end

    generate
        if (GRAY) begin : g_gray
            assign state_q = cnt_q ^ (cnt_q >> 1);
        end else begin : g_bin
            assign state_q = cnt_q;
        end
    endgenerate

    assign state_en = oe;
    assign sdrd     = ^cnt_q;
    assign sdrd_en  = (fsm_q == S_RUN) & qual;
    assign strobe   = (fsm_q == S_MATCH);
    assign done     = (fsm_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_cle_seq_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_cle_seq_gen
// Brief   : Scoreboard bench for cle_seq_gen, binary and Gray instances.
// Revision: 1.0
// ============================================================================
module tb_cle_seq_gen;

    localparam int         STATE_W = 6;
    localparam int         ADDR_W  = 4;
    localparam logic [1:0] BASE    = 2'b01;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic sser_n = 1'b1;
    logic br_w   = 1'b0;
    logic oe     = 1'b0;
    logic [1:0]        ba_hi    = 2'b00;
    logic [ADDR_W-1:0] ba_field = '0;

    logic [STATE_W-1:0] sq0, sq1;
    logic en0, en1, sd0, sd1, sde0, sde1, st0, st1, dn0, dn1;

    cle_seq_gen #(.STATE_W(STATE_W), .ADDR_W(ADDR_W), .BASE(BASE), .GRAY(1'b0)) u_bin (
        .clk(clk), .rst_n(rst_n), .sser_n(sser_n), .ba_hi(ba_hi), .ba_field(ba_field),
        .br_w(br_w), .oe(oe), .state_q(sq0), .state_en(en0), .sdrd(sd0),
        .sdrd_en(sde0), .strobe(st0), .done(dn0)
    );

    cle_seq_gen #(.STATE_W(STATE_W), .ADDR_W(ADDR_W), .BASE(BASE), .GRAY(1'b1)) u_gray (
        .clk(clk), .rst_n(rst_n), .sser_n(sser_n), .ba_hi(ba_hi), .ba_field(ba_field),
        .br_w(br_w), .oe(oe), .state_q(sq1), .state_en(en1), .sdrd(sd1),
        .sdrd_en(sde1), .strobe(st1), .done(dn1)
    );

    always #5 clk = ~clk;

    typedef logic [21:0] vec_t;
    vec_t exp_q[$];
    vec_t mon_e, mon_a;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    // Reference state: k = consecutive qualified edges since last abort/reset.
    int k   = 0;
    int tgt = 0;

    function automatic vec_t expect_vec(int kk, int tt, bit q, bit o);
        int         c;
        logic [5:0] b, g;
        bit         par, se, st, dn;
        c   = (kk <= 1) ? 0 : ((kk - 2 < tt) ? kk - 2 : tt);
        b   = 6'(c);
        g   = b ^ (b >> 1);
        par = ($countones(c) % 2) == 1;
        se  = q && (kk >= 2) && (kk <= 2 + tt);
        st  = (kk == 3 + tt);
        dn  = (kk >= 4 + tt);
        return {b, g, o, o, par, par, se, se, st, st, dn, dn};
    endfunction

    task automatic cycle(input bit r, input bit s, input logic [1:0] h,
                         input logic [ADDR_W-1:0] f, input bit w, input bit o);
        bit q;
        rst_n    = r;
        sser_n   = s;
        ba_hi    = h;
        ba_field = f;
        br_w     = w;
        oe       = o;
        q = !s && (h == BASE) && w;
        if (!r) k = 0;
        exp_q.push_back(expect_vec(k, tgt, q, o));
        @(posedge clk);
        if (r) begin
            if (!q) begin
                k = 0;
            end else begin
                if (k == 0) tgt = int'(f);
                if (k < 100) k++;
            end
        end
        #1;
    endtask

    task automatic qcyc(input logic [ADDR_W-1:0] f);
        cycle(1'b1, 1'b0, BASE, f, 1'b1, 1'($urandom));
    endtask

    task automatic nq();
        cycle(1'b1, 1'b1, BASE, 4'($urandom), 1'b1, 1'($urandom));
    endtask

    always @(negedge clk) begin
        cyc++;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a = {sq0, sq1, en0, en1, sd0, sd1, sde0, sde1, st0, st1, dn0, dn1};
            n_tests++;
            if (mon_a !== mon_e) begin
                n_fail++;
                $display("FAIL outputs cyc=%0d got=%h exp=%h (sqb sqg en sdrd sdrd_en strobe done)",
                         cyc, mon_a, mon_e);
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        repeat (3) cycle(1'b0, 1'b0, BASE, 4'($urandom), 1'b1, 1'($urandom));
        nq();
        repeat (10) qcyc(4'h3);
        nq();
        repeat (6) qcyc(4'h0);
        nq();
        // Abort in RUN at cnt=2, then re-arm with a new target while ba_field wanders.
        repeat (4) qcyc(4'h5);
        nq();
        qcyc(4'h2);
        repeat (7) qcyc(4'($urandom));
        nq();
        repeat (22) qcyc(4'hF);
        nq();
        repeat (4) cycle(1'b1, 1'b0, 2'b11, 4'($urandom), 1'b1, 1'b1);
        repeat (4) cycle(1'b1, 1'b0, BASE, 4'($urandom), 1'b0, 1'b1);
        // Reset asserted between edges while in DONE, released with qual high.
        repeat (6) qcyc(4'h1);
        cycle(1'b0, 1'b0, BASE, 4'h1, 1'b1, 1'b1);
        repeat (5) qcyc(4'h2);
        nq();
        for (int i = 0; i < 400; i++) begin
            bit r;
            r = ($urandom_range(0, 49) != 0);
            if ($urandom_range(0, 9) < 8)
                cycle(r, 1'b0, BASE, 4'($urandom), 1'b1, 1'($urandom));
            else
                cycle(r, 1'($urandom), 2'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got=%0d pending required=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
